// File: rtl/gpio_pulse_rx_pkg.sv
// Shared types and constants for the GPIO pulse receive path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gpio_pkg;

    localparam int GPIO_WIDTH_W = 8;
    localparam int GPIO_CNT_W   = 32;
    localparam int GPIO_TS_W    = 64;

    typedef enum logic [1:0] {
        ST_ARM  = 2'd0,
        ST_IDLE = 2'd1,
        ST_HIGH = 2'd2
    } state_t;

    typedef struct packed {
        logic [GPIO_TS_W-1:0]    ts;
        logic [GPIO_WIDTH_W-1:0] width;
    } gpio_evt_t;

    // Width counter increment that sticks at all-ones.
    function automatic logic [GPIO_WIDTH_W-1:0] sat_inc(input logic [GPIO_WIDTH_W-1:0] v);
        return (v == {GPIO_WIDTH_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/gpio_pulse_rx_if.sv
// Captured-pulse event channel: one-deep valid/ready with timestamp and width.
// Latency: n/a (wiring only).
// Backpressure: producer holds valid/ts/width stable until valid && ready.
interface gpio_pulse_rx_if #(
    parameter int TS_WIDTH = 64
);
    import gpio_pkg::*;

    logic                    valid;
    logic                    ready;
    logic [TS_WIDTH-1:0]     ts;
    logic [GPIO_WIDTH_W-1:0] width;

    modport master (output valid, output ts, output width, input ready);
    modport slave  (input valid, input ts, input width, output ready);

endinterface

// File: rtl/gpio_pulse_rx_sync.sv
// Module gpio_sync: STAGES-flop synchroniser for an asynchronous pin, reset to 0.
// Latency: STAGES clk edges from din to dout.
// Backpressure: none.
// Ports: clk, rst_n (async, active-low), din (async pin), dout (synchronised level).
module gpio_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    logic [STAGES-1:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else begin
            sr <= {sr[STAGES-2:0], din};
        end
    end

    assign dout = sr[STAGES-1];

endmodule

// File: rtl/gpio_pulse_rx.sv
// Captures pulses on an external pin: width measurement, range check, rising-edge timestamp.
// Latency: event valid 1 clk after the first synchronised-low cycle (SYNC_STAGES+1 after pin fall).
// Backpressure: one-deep hold register; accepted pulses arriving while it is held are counted and dropped.
// Ports: clk, rst_n, gpio_in, ts_now, cfg_enable/min/max, evt (master), pulse/reject/overflow counters.
// Build option: GPIO_RX_TS_COMP_EN subtracts (SYNC_STAGES+1) from the captured timestamp.
module gpio_pulse_rx
    import gpio_pkg::*;
#(
    parameter int SYNC_STAGES      = 2,
    parameter int MIN_WIDTH_CYCLES = 4,
    parameter int TS_WIDTH         = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  gpio_in,
    input  logic [TS_WIDTH-1:0]   ts_now,
    input  logic                  cfg_enable,
    input  logic [7:0]            cfg_min_width,
    input  logic [7:0]            cfg_max_width,
    gpio_pulse_rx_if.master       evt,
    output logic [GPIO_CNT_W-1:0] pulse_count,
    output logic [GPIO_CNT_W-1:0] reject_count,
    output logic [GPIO_CNT_W-1:0] overflow_count
);

    state_t                  state, state_nxt;
    logic                    s;
    logic [TS_WIDTH-1:0]     ts_cap;
    logic [GPIO_WIDTH_W-1:0] width;
    logic [GPIO_WIDTH_W-1:0] eff_min;
    logic                    width_ok;
    logic                    start;
    logic                    eval;
    logic                    accept;
    logic                    reject;
    logic                    load;
    logic                    drop;
    logic                    drain;
    logic [TS_WIDTH-1:0]     ts_evt;

    gpio_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (gpio_in),
        .dout (s)
    );

    assign eff_min  = (cfg_min_width == 8'd0) ? GPIO_WIDTH_W'(MIN_WIDTH_CYCLES) : cfg_min_width;
    assign width_ok = (width >= eff_min) &&
                      ((cfg_max_width == 8'd0) || (width <= cfg_max_width));

`ifdef GPIO_RX_TS_COMP_EN
    // Back out synchroniser + edge-detect delay so ts points at the pin edge.
    assign ts_evt = ts_cap - TS_WIDTH'(SYNC_STAGES + 1);
`else
    assign ts_evt = ts_cap;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_ARM;
        end else begin
            state <= state_nxt;
        end
    end

    // Disable always wins over edge handling so a partial pulse is never evaluated.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        eval      = 1'b0;
        unique case (state)
            ST_ARM: begin
                // Only arm on a low line: a stuck-high or mid-pulse enable is ignored.
                if (cfg_enable && !s) state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                if (!cfg_enable) begin
                    state_nxt = ST_ARM;
                end else if (s) begin
                    state_nxt = ST_HIGH;
                    start     = 1'b1;
                end
            end
            ST_HIGH: begin
                if (!cfg_enable) begin
                    state_nxt = ST_ARM;
                end else if (!s) begin
                    state_nxt = ST_IDLE;
                    eval      = 1'b1;
                end
            end
            default: state_nxt = ST_ARM;
        endcase
    end

    assign accept = eval && width_ok;
    assign reject = eval && !width_ok;
    assign drain  = evt.valid && evt.ready;
    // A draining register can take the new event in the same cycle.
    assign load   = accept && (!evt.valid || evt.ready);
    assign drop   = accept && !load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_cap <= '0;
            width  <= '0;
        end else if (start) begin
            ts_cap <= ts_now;
            width  <= GPIO_WIDTH_W'(1);
        end else if (state == ST_HIGH && s) begin
            width  <= sat_inc(width);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt.valid <= 1'b0;
            evt.ts    <= '0;
            evt.width <= '0;
        end else if (load) begin
            evt.valid <= 1'b1;
            evt.ts    <= ts_evt;
            evt.width <= width;
        end else if (drain) begin
            evt.valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse_count    <= '0;
            reject_count   <= '0;
            overflow_count <= '0;
        end else begin
            if (accept) pulse_count    <= pulse_count + 1'b1;
            if (reject) reject_count   <= reject_count + 1'b1;
            if (drop)   overflow_count <= overflow_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_gpio_pulse_rx.sv
// Self-checking bench for gpio_pulse_rx: pulse table plus handshake/enable/reset sequences.
module tb_gpio_pulse_rx;
    import gpio_pkg::*;

    localparam int SS  = 2;
    localparam int TSW = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        gpio_in = 1'b0;
    logic        cfg_enable = 1'b0;
    logic [7:0]  cfg_min_width = 8'd0;
    logic [7:0]  cfg_max_width = 8'd0;
    logic [63:0] ts_now = 64'd0;
    logic [31:0] pulse_count, reject_count, overflow_count;

    gpio_pulse_rx_if #(.TS_WIDTH(TSW)) evt();

    gpio_pulse_rx #(
        .SYNC_STAGES     (SS),
        .MIN_WIDTH_CYCLES(4),
        .TS_WIDTH        (TSW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .gpio_in       (gpio_in),
        .ts_now        (ts_now),
        .cfg_enable    (cfg_enable),
        .cfg_min_width (cfg_min_width),
        .cfg_max_width (cfg_max_width),
        .evt           (evt),
        .pulse_count   (pulse_count),
        .reject_count  (reject_count),
        .overflow_count(overflow_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) ts_now <= ts_now + 64'd1;

    typedef struct {
        int         w;
        logic [7:0] mn;
        logic [7:0] mx;
        bit         acc;
        logic [7:0] ew;
    } vec_t;

    typedef struct {
        logic [63:0] ts;
        logic [7:0]  width;
    } exp_t;

    vec_t vt[11];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   exp_pc = 0, exp_rc = 0, exp_oc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [63:0] exp_ts(input logic [63:0] t);
`ifdef GPIO_RX_TS_COMP_EN
        return t + SS - (SS + 1);
`else
        return t + SS;
`endif
    endfunction

    // Scoreboard pop on every completed transfer.
    task automatic monitor();
        exp_t e;
        if (evt.valid && evt.ready) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_event: got ts=%0d width=%0d, expected no event", evt.ts, evt.width);
            end else begin
                e = sb.pop_front();
                check("evt_ts", evt.ts, e.ts);
                check("evt_width", 64'(evt.width), 64'(e.width));
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            monitor();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input int n, output logic [63:0] t);
        t = ts_now;
        gpio_in = 1'b1;
        tick(n);
        gpio_in = 1'b0;
    endtask

    task automatic push(input logic [63:0] t, input logic [7:0] w);
        exp_t e;
        e.ts = exp_ts(t);
        e.width = w;
        sb.push_back(e);
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_pulse_count"}, 64'(pulse_count), 64'(exp_pc));
        check({tag, "_reject_count"}, 64'(reject_count), 64'(exp_rc));
        check({tag, "_overflow_count"}, 64'(overflow_count), 64'(exp_oc));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 64'(evt.valid), 64'd0);
        check({tag, "_ts"}, evt.ts, 64'd0);
        check({tag, "_width"}, 64'(evt.width), 64'd0);
        check({tag, "_pulse_count"}, 64'(pulse_count), 64'd0);
        check({tag, "_reject_count"}, 64'(reject_count), 64'd0);
        check({tag, "_overflow_count"}, 64'(overflow_count), 64'd0);
    endtask

    initial begin
        logic [63:0] t;
        int guard;

        //        w    min    max    acc  width
        vt[0]  = '{10,  8'd0, 8'd0,  1'b1, 8'd10};
        vt[1]  = '{2,   8'd0, 8'd0,  1'b0, 8'd0};
        vt[2]  = '{30,  8'd0, 8'd20, 1'b0, 8'd0};
        vt[3]  = '{4,   8'd0, 8'd20, 1'b1, 8'd4};
        vt[4]  = '{3,   8'd0, 8'd0,  1'b0, 8'd0};
        vt[5]  = '{6,   8'd6, 8'd20, 1'b1, 8'd6};
        vt[6]  = '{5,   8'd6, 8'd20, 1'b0, 8'd0};
        vt[7]  = '{20,  8'd6, 8'd20, 1'b1, 8'd20};
        vt[8]  = '{21,  8'd6, 8'd20, 1'b0, 8'd0};
        vt[9]  = '{300, 8'd0, 8'd0,  1'b1, 8'd255};
        vt[10] = '{1,   8'd1, 8'd0,  1'b1, 8'd1};

        evt.ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        cfg_enable = 1'b1;
        tick(3);

        // First pulse rises at ts 100 so the synchronised edge lands on 102.
        guard = 0;
        while (ts_now < 64'd100 && guard < 200) begin
            tick(1);
            guard++;
        end

        for (int i = 0; i < 11; i++) begin
            cfg_min_width = vt[i].mn;
            cfg_max_width = vt[i].mx;
            pulse(vt[i].w, t);
            if (vt[i].acc) begin
                push(t, vt[i].ew);
                exp_pc++;
            end else begin
                exp_rc++;
            end
            tick(SS + 6);
            check($sformatf("vec%0d_sb_drained", i), 64'(sb.size()), 64'd0);
            check_counts($sformatf("vec%0d", i));
            tick(2);
        end

        // Held event with a second accepted pulse arriving: second is dropped.
        cfg_min_width = 8'd0;
        cfg_max_width = 8'd0;
        evt.ready = 1'b0;
        pulse(8, t);
        push(t, 8'd8);
        exp_pc++;
        tick(SS + 6);
        pulse(12, t);
        exp_pc++;
        exp_oc++;
        tick(SS + 6);
        check("hold_valid", 64'(evt.valid), 64'd1);
        check("hold_width", 64'(evt.width), 64'd8);
        check_counts("hold");
        evt.ready = 1'b1;
        tick(1);
        evt.ready = 1'b0;
        check("hold_valid_after_drain", 64'(evt.valid), 64'd0);
        check("hold_sb_drained", 64'(sb.size()), 64'd0);
        evt.ready = 1'b1;
        tick(2);

        // Enable dropped in the 5th high cycle: nothing counted, nothing emitted.
        gpio_in = 1'b1;
        tick(4);
        cfg_enable = 1'b0;
        tick(1);
        cfg_enable = 1'b1;
        tick(5);
        gpio_in = 1'b0;
        tick(SS + 6);
        check("abort_valid", 64'(evt.valid), 64'd0);
        check_counts("abort");
        pulse(7, t);
        push(t, 8'd7);
        exp_pc++;
        tick(SS + 6);
        check_counts("rearm");

        // Line stuck high through reset release and enable.
        rst_n = 1'b0;
        gpio_in = 1'b1;
        cfg_enable = 1'b0;
        tick(2);
        rst_n = 1'b1;
        exp_pc = 0;
        exp_rc = 0;
        exp_oc = 0;
        tick(3);
        cfg_enable = 1'b1;
        tick(20);
        check("stuck_valid", 64'(evt.valid), 64'd0);
        check_counts("stuck");
        gpio_in = 1'b0;
        tick(5);
        pulse(6, t);
        push(t, 8'd6);
        exp_pc++;
        tick(SS + 6);
        check_counts("after_stuck");
        check("after_stuck_sb_drained", 64'(sb.size()), 64'd0);

        // Reset asserted mid-pulse with an event held.
        evt.ready = 1'b0;
        pulse(5, t);
        tick(SS + 6);
        check("pre_reset_valid", 64'(evt.valid), 64'd1);
        check("pre_reset_width", 64'(evt.width), 64'd5);
        gpio_in = 1'b1;
        tick(4);
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        gpio_in = 1'b0;
        evt.ready = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        check("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/gpio_pulse_rx.md
Name: gpio_pulse_rx

Overview:
Input-side counterpart of the GPIO action output. Captures pulses on an external FPGA input pin, such as a venue or loopback acknowledge line. Synchronises the pin and measures the pulse width in clk cycles. Timestamps the rising edge and rejects pulses whose width is out of range. Each accepted pulse is presented as a one-deep valid/ready event to the latency-stats logic, and CSR-visible statistics are maintained.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops on gpio_in (legal range 2..4).
MIN_WIDTH_CYCLES, 4, default minimum accepted width; used when cfg_min_width==0.
TS_WIDTH, 64, timestamp width.

Ports:
clk  in  1  core clock
rst_n  in  1  reset, asynchronous, active-low
gpio_in  in  1  asynchronous physical input pin
ts_now  in  TS_WIDTH  free-running timestamp counter
cfg_enable  in  1  capture enable
cfg_min_width  in  8  minimum accepted width; 0 = MIN_WIDTH_CYCLES
cfg_max_width  in  8  maximum accepted width; 0 = no maximum check
evt_valid  out  1  captured event available
evt_ready  in  1  consumer accepts event
evt_ts  out  TS_WIDTH  rising-edge timestamp
evt_width  out  8  pulse width in cycles, saturating at 255
pulse_count  out  32  accepted pulses
reject_count  out  32  pulses rejected as too short or too long
overflow_count  out  32  accepted pulses dropped because an event was still held

Behaviour:
- Synchroniser: gpio_in passes through SYNC_STAGES flops, all reset to 0. The last stage is s.
- Reset values: all outputs 0; state ST_ARM.
- ST_ARM: wait until cfg_enable==1 and s==0, then go to ST_IDLE. This rejects a line that is stuck high or that is enabled mid-pulse.
- ST_IDLE: when s==1, latch ts_cap<=ts_now, set width<=1, go to ST_HIGH.
- ST_HIGH, while s==1: width increments, saturating at 255.
- ST_HIGH, first cycle with s==0: evaluate width against the limits, then go to ST_IDLE.
  - If width < eff_min, or (cfg_max_width!=0 and width > cfg_max_width): reject_count++, no event.
  - Otherwise the pulse is accepted.
- Accepted pulse with the holding register empty, or with evt_valid&&evt_ready in that same cycle: load evt_ts/evt_width, evt_valid<=1 on the next clk, pulse_count++.
- Accepted pulse with the holding register occupied and not being drained: the new pulse is dropped and the held event is kept. overflow_count++ and pulse_count++.
- Latency from gpio_in to evt_valid:
  - A rising edge of gpio_in reaches s after SYNC_STAGES clk edges.
  - evt_valid rises 1 clk after the first cycle in which s==0.
- Width accounting: a gpio_in high for exactly N cycles gives evt_width==N.
- Handshake:
  - evt_valid holds, with evt_ts/evt_width stable, until evt_valid&&evt_ready.
  - On that transfer evt_valid clears on the next clk, unless a new accepted event loads in the same cycle; then evt_valid stays 1 with the new data.
- cfg_enable==0 in ST_IDLE or ST_HIGH: abort to ST_ARM in the next cycle. A partially measured pulse produces no event and no count. An already-held event is still presented and drained.
- Counters are 32-bit and wrap from 0xFFFFFFFF to 0.
- Asynchronous reset mid-pulse or mid-handshake clears everything immediately. The next capture needs ST_ARM to see s==0 first.

Optional Feature:
Macro GPIO_RX_TS_COMP_EN.
- Defined: evt_ts = ts_cap − (SYNC_STAGES+1), in modulo-2^TS_WIDTH arithmetic. This compensates for synchroniser and edge-detect delay so evt_ts approximates the cycle gpio_in rose.
- Undefined: evt_ts = ts_cap, uncompensated.

Decomposition:
- Shared package gpio_pkg holds:
  - the state_t enum {ST_ARM, ST_IDLE, ST_HIGH};
  - GPIO_WIDTH_W=8 and GPIO_CNT_W=32;
  - a packed gpio_evt_t struct {ts, width}.
- One natural sub-module: gpio_sync, a parameterised SYNC_STAGES-flop synchroniser with asynchronous reset to 0. It is reusable by other pin inputs.

Test Plan:
1. SYNC_STAGES=2, enable=1, evt_ready=1, gpio_in high 10 cycles, ts_now = cycle index, s rises at ts=102 -> one event: evt_width=10, evt_ts=102 (99 with GPIO_RX_TS_COMP_EN), pulse_count=1.
2. cfg_min_width=0, gpio_in high 2 cycles -> no evt_valid, reject_count=1. With cfg_max_width=20, a 30-cycle pulse -> no event, reject_count=2.
3. gpio_in held high through reset release and enable -> no event. Line drops low, then a 6-cycle pulse -> exactly one event with width 6.
4. evt_ready=0, two valid pulses of 8 and 12 cycles -> evt_width stays 8, overflow_count=1, pulse_count=2. evt_ready=1 for one cycle -> evt_valid drops the next cycle.
5. gpio_in high 300 cycles -> evt_width=255.
6. cfg_enable dropped during the 5th cycle of a high pulse -> no event, no counter change. Asserting rst_n low mid-pulse clears all outputs to 0.
